cdwu_arb: RTL
=============

Name: cdwu_arb

Overview:
Parametrised N-channel conflict-detection write arbiter for one memory bank port. It is the successor of the 3-channel fixed-priority write unit. Each cycle it grants at most one of NCH write requesters, using either fixed priority with starvation override or round-robin. The chosen enable, address and select code are registered toward the bank write mux/SRAM.

Parameters:
NCH, 3, number of requesting channels (>=1); channel 0 is highest fixed priority
BANKBITS, 5, bank-select address bits
WORDBITS, 9, word address bits; A = BANKBITS+WORDBITS
RRMODE, 0, 0 = fixed priority with starvation override; 1 = round-robin
MAXWAIT, 15, consecutive denied cycles after which a channel is starved (>=1)
SELBITS, derived = max(1, clog2(NCH)), width of select code

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_en  in  NCH  per-channel write request
req_addr  in  NCH*A  channel k address at bits [k*A +: A]
req_grnt  out  NCH  combinational one-hot grant, same cycle as request
o_en  out  1  registered: a write was granted last cycle
o_addr  out  A  registered address of last grant
o_sel  out  SELBITS  registered index of granted channel (mux code)
o_starve  out  NCH  registered: channel wait counter == MAXWAIT

Behaviour:
- Reset (rst_n low, asynchronous): o_en=0, o_addr=0, o_sel=0, o_starve=0, all wait counters=0, RR pointer=0. req_grnt forced to 0 while rst_n low. Reset mid-operation drops any in-flight registered write: o_en is 0 the cycle after reset asserts, and there is no replay.
- req_grnt is always one-hot or zero. It is zero iff req_en==0. It is never asserted for a channel with req_en low.
- Fixed mode (RRMODE=0):
  - If any requesting channel has wait counter == MAXWAIT, grant the lowest-index such channel.
  - Otherwise grant the lowest-index requesting channel.
- Round-robin mode (RRMODE=1):
  - Search starts at pointer p and wraps: p, p+1 … NCH-1, 0 … p-1. The first requester found is granted.
  - On a grant to k: p <= (k+1) mod NCH, so k = NCH-1 wraps p to 0.
  - No grant: p unchanged.
  - The starvation override is not used in this mode.
- Wait counters (one per channel, width clog2(MAXWAIT+1)), both modes:
  - req_en[k] & ~req_grnt[k]: increment, saturating at MAXWAIT.
  - Granted, or req_en[k] low: clear to 0.
  - o_starve[k] <= (next counter == MAXWAIT).
- Output register, latency 1 cycle from grant:
  - o_en <= |req_grnt.
  - With a grant: o_addr <= granted channel's address, o_sel <= its index.
  - No grant: o_addr and o_sel hold their previous values.
- Requesters are expected to hold req_en and req_addr until granted. The block does not latch ungranted requests.
- NCH=1: req_grnt = req_en, o_sel always 0, RR pointer stays 0.
- Simultaneous starvation of several channels: the lowest index wins. The losers keep counting, saturated at MAXWAIT.
- With RRMODE=0, NCH=3 and MAXWAIT never reached, behaviour is cycle-identical to the 3-channel unit, plus the 1-cycle output register.

Test Plan:
- Fixed, NCH=3: req_en=3'b111 for 1 cycle -> req_grnt=3'b001 same cycle; next cycle o_en=1, o_sel=0, o_addr=req_addr[0].
- Fixed, MAXWAIT=3: req_en=3'b101 held -> grants ch0 in cycles 0-2, ch2 in cycle 3 (counter=3), ch0 in cycle 4. o_starve[2]=1 in cycle 3 only; o_sel=2 in cycle 4.
- RR, NCH=3: req_en=3'b111 held 6 cycles -> grants 0,1,2,0,1,2. Then req_en=3'b100 for 1 cycle -> grant 2, pointer wraps to 0.
- Idle: after a grant of addr 0x1A5 via ch1, req_en=0 for 3 cycles -> req_grnt=0, o_en=0, o_addr stays 0x1A5, o_sel stays 1.
- Reset mid-op: rst_n pulled low asynchronously between edges with requests active -> o_en/o_addr/o_sel/o_starve/req_grnt are 0 immediately. After release, RR grant restarts at ch0 and counters restart at 0.
- NCH=1, RRMODE=1: toggle req_en -> req_grnt follows req_en, o_sel=0, o_starve never set.

Source files
------------

// File: rtl/cdwu_arb.sv
// rtl/cdwu_arb.sv - N-channel bank write arbiter with starvation override or round-robin
// Grants at most one requester per cycle and registers enable/address/select toward the bank.
module cdwu_arb #(
  parameter int NCH      = 3,
  parameter int BANKBITS = 5,
  parameter int WORDBITS = 9,
  parameter int RRMODE   = 0,
  parameter int MAXWAIT  = 15,
  localparam int A       = BANKBITS + WORDBITS,
  localparam int SELBITS = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NCH-1:0]     req_en,
  input  logic [NCH*A-1:0]   req_addr,
  output logic [NCH-1:0]     req_grnt,
  output logic               o_en,
  output logic [A-1:0]       o_addr,
  output logic [SELBITS-1:0] o_sel,
  output logic [NCH-1:0]     o_starve
);

  localparam int CW = $clog2(MAXWAIT + 1);
  localparam logic [CW-1:0] MAXW = CW'(MAXWAIT);

  logic [CW-1:0]      r_cnt [NCH];
  logic [SELBITS-1:0] r_ptr;
  logic               r_en;
  logic [A-1:0]       r_addr;
  logic [SELBITS-1:0] r_sel;
  logic [NCH-1:0]     r_starve;

  logic               w_hi_found, w_lo_found, w_st_found;
  logic [SELBITS-1:0] w_hi_idx, w_lo_idx, w_st_idx;
  logic [SELBITS-1:0] w_idx, w_ptr_nxt;
  logic [NCH-1:0]     w_grnt;
  logic [A-1:0]       w_addr;
  logic [CW-1:0]      w_cnt_nxt [NCH];

  // Descending scan leaves the lowest matching index; requesters at or above the
  // pointer form the first search segment. In fixed mode the pointer stays 0.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_st_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    w_st_idx   = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (req_en[k]) begin
        if (k >= int'(r_ptr)) begin
          w_hi_found = 1'b1;
          w_hi_idx   = SELBITS'(k);
        end else begin
          w_lo_found = 1'b1;
          w_lo_idx   = SELBITS'(k);
        end
        if (r_cnt[k] == MAXW) begin
          w_st_found = 1'b1;
          w_st_idx   = SELBITS'(k);
        end
      end
    end
  end

  always_comb begin
    w_idx = '0;
    if (RRMODE == 0 && w_st_found) w_idx = w_st_idx;
    else if (w_hi_found)           w_idx = w_hi_idx;
    else if (w_lo_found)           w_idx = w_lo_idx;
    w_ptr_nxt = (w_idx == SELBITS'(NCH - 1)) ? '0 : w_idx + SELBITS'(1);
  end

  always_comb begin
    w_grnt = '0;
    w_addr = '0;
    for (int k = 0; k < NCH; k++) begin
      w_grnt[k] = rst_n & req_en[k] & (w_idx == SELBITS'(k));
      if (w_idx == SELBITS'(k)) w_addr = req_addr[k*A +: A];
    end
  end

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      w_cnt_nxt[k] = '0;
      if (req_en[k] && !w_grnt[k])
        w_cnt_nxt[k] = (r_cnt[k] == MAXW) ? r_cnt[k] : r_cnt[k] + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en     <= 1'b0;
      r_addr   <= '0;
      r_sel    <= '0;
      r_starve <= '0;
      r_ptr    <= '0;
      for (int k = 0; k < NCH; k++) r_cnt[k] <= '0;
    end else begin
      r_en <= |w_grnt;
      if (|w_grnt) begin
        r_addr <= w_addr;
        r_sel  <= w_idx;
        if (RRMODE != 0) r_ptr <= w_ptr_nxt;
      end
      for (int k = 0; k < NCH; k++) begin
        r_cnt[k]    <= w_cnt_nxt[k];
        r_starve[k] <= (w_cnt_nxt[k] == MAXW);
      end
    end
  end

  assign req_grnt = w_grnt;
  assign o_en     = r_en;
  assign o_addr   = r_addr;
  assign o_sel    = r_sel;
  assign o_starve = r_starve;

endmodule
